// File: rtl/fg_period_sequencer.sv
// Period sequencer for the function-generator datapath: prescaled clock-enable, period counter CR,
// and shadowed waveform configuration committed only at period wraps. Define FG_BURST_EN for burst mode.
module fg_period_sequencer #(
  parameter int unsigned COUNTER_BITWIDTH   = 32,
  parameter int unsigned WAVEFORM_BITWIDTH  = 16,
  parameter int unsigned PRESCALER_BITWIDTH = 8
`ifdef FG_BURST_EN
  , parameter int unsigned BURST_BITWIDTH   = 16
`endif
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
`ifdef FG_BURST_EN
  input  logic [BURST_BITWIDTH-1:0]     burst_count_i,
`endif
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [COUNTER_BITWIDTH-1:0]   cfg_period_i,
  input  logic [COUNTER_BITWIDTH-1:0]   cfg_on_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_amplitude_i,
  output logic                          clk_en_o,
  output logic [COUNTER_BITWIDTH-1:0]   CR_o,
  output logic [COUNTER_BITWIDTH-1:0]   counter_o,
  output logic [COUNTER_BITWIDTH-1:0]   ON_counter_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_fall_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  amplitude_o,
  output logic                          busy_o,
  output logic                          period_done_o,
  output logic                          done_o
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t state, state_next;

  logic [PRESCALER_BITWIDTH-1:0] presc;
  logic [PRESCALER_BITWIDTH-1:0] presc_cnt;
  logic [COUNTER_BITWIDTH-1:0]   sh_period;
  logic [COUNTER_BITWIDTH-1:0]   sh_on;
  logic [WAVEFORM_BITWIDTH-1:0]  sh_k_rise;
  logic [WAVEFORM_BITWIDTH-1:0]  sh_k_fall;
  logic [WAVEFORM_BITWIDTH-1:0]  sh_amplitude;
  logic tick, wrap, go, last_period, handshake, commit, burst_last;

`ifdef FG_BURST_EN
  logic [BURST_BITWIDTH-1:0] burst_len;
  logic [BURST_BITWIDTH-1:0] burst_cnt;
  assign burst_last = (burst_len != '0) && ((burst_cnt + BURST_BITWIDTH'(1)) == burst_len);
`else
  assign burst_last = 1'b0;
`endif

  assign tick      = (state != IDLE) && (presc_cnt == '0);
  assign wrap      = tick && (CR_o == counter_o);
  assign clk_en_o  = tick;
  assign busy_o    = (state != IDLE);
  assign handshake = cfg_valid_i && cfg_ready_o;
  // A pending shadow commits immediately when idle, otherwise only on a wrap edge.
  assign commit    = !cfg_ready_o && ((state == IDLE) || wrap);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    go          = 1'b0;
    last_period = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_next = RUN;
          go         = 1'b1;
        end
      end
      RUN: begin
        if (wrap && burst_last) begin
          state_next  = IDLE;
          last_period = 1'b1;
        end else if (stop_i) begin
          state_next = STOPPING;
        end
      end
      STOPPING: begin
        if (wrap) begin
          state_next  = IDLE;
          last_period = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc         <= '0;
      presc_cnt     <= '0;
      CR_o          <= '0;
      period_done_o <= 1'b0;
      done_o        <= 1'b0;
`ifdef FG_BURST_EN
      burst_len     <= '0;
      burst_cnt     <= '0;
`endif
    end else begin
      period_done_o <= wrap;
      done_o        <= last_period;
      if (go) begin
        presc     <= prescaler_i;
        presc_cnt <= '0;
        CR_o      <= '0;
`ifdef FG_BURST_EN
        burst_len <= burst_count_i;
        burst_cnt <= '0;
`endif
      end else if (state != IDLE) begin
        presc_cnt <= (presc_cnt == presc) ? '0 : presc_cnt + PRESCALER_BITWIDTH'(1);
        if (tick) CR_o <= wrap ? '0 : CR_o + COUNTER_BITWIDTH'(1);
`ifdef FG_BURST_EN
        if (wrap) burst_cnt <= burst_cnt + BURST_BITWIDTH'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cfg_ready_o  <= 1'b1;
      sh_period    <= '0;
      sh_on        <= '0;
      sh_k_rise    <= '0;
      sh_k_fall    <= '0;
      sh_amplitude <= '0;
      counter_o    <= '0;
      ON_counter_o <= '0;
      k_rise_o     <= '0;
      k_fall_o     <= '0;
      amplitude_o  <= '0;
    end else begin
      if (handshake) begin
        cfg_ready_o  <= 1'b0;
        sh_period    <= cfg_period_i;
        sh_on        <= cfg_on_i;
        sh_k_rise    <= cfg_k_rise_i;
        sh_k_fall    <= cfg_k_fall_i;
        sh_amplitude <= cfg_amplitude_i;
      end
      if (commit) begin
        cfg_ready_o  <= 1'b1;
        counter_o    <= sh_period;
        ON_counter_o <= sh_on;
        k_rise_o     <= sh_k_rise;
        k_fall_o     <= sh_k_fall;
        amplitude_o  <= sh_amplitude;
      end
    end
  end

endmodule

// File: tb/tb_fg_period_sequencer.sv
// Directed self-checking bench for fg_period_sequencer; burst scenario built only with FG_BURST_EN.
module tb_fg_period_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stop;
  logic [7:0]  prescaler;
`ifdef FG_BURST_EN
  logic [15:0] burst_count;
`endif
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_period, cfg_on;
  logic [15:0] cfg_k_rise, cfg_k_fall, cfg_amplitude;
  logic        clk_en;
  logic [31:0] cr, counter, on_counter;
  logic [15:0] k_rise, k_fall, amplitude;
  logic        busy, period_done, done;

  int errors = 0;
  int checks = 0;

  fg_period_sequencer dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop), .prescaler_i(prescaler),
`ifdef FG_BURST_EN
    .burst_count_i(burst_count),
`endif
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_period_i(cfg_period), .cfg_on_i(cfg_on),
    .cfg_k_rise_i(cfg_k_rise), .cfg_k_fall_i(cfg_k_fall), .cfg_amplitude_i(cfg_amplitude),
    .clk_en_o(clk_en), .CR_o(cr), .counter_o(counter), .ON_counter_o(on_counter),
    .k_rise_o(k_rise), .k_fall_o(k_fall), .amplitude_o(amplitude),
    .busy_o(busy), .period_done_o(period_done), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] per, input logic [31:0] on,
                         input logic [15:0] kr, input logic [15:0] kf, input logic [15:0] amp);
    cfg_period = per; cfg_on = on; cfg_k_rise = kr; cfg_k_fall = kf; cfg_amplitude = amp;
  endtask

  task automatic load_idle(input logic [31:0] per, input logic [31:0] on,
                           input logic [15:0] kr, input logic [15:0] kf, input logic [15:0] amp);
    set_cfg(per, on, kr, kf, amp);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; stop = 1'b0; prescaler = '0; cfg_valid = 1'b0;
`ifdef FG_BURST_EN
    burst_count = '0;
`endif
    set_cfg(0, 0, 0, 0, 0);
    step(); step();
    checks++; if (cr !== 32'd0) begin errors++; $display("FAIL reset_cr: got %0d expected 0", cr); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b expected 0", clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    checks++; if (counter !== 32'd0) begin errors++; $display("FAIL reset_counter: got %0d expected 0", counter); end
    checks++; if ({period_done, done} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {period_done, done}); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_cfg(4, 2, 1, 1, 2);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL idle_ready_low: got %b expected 0", cfg_ready); end
    checks++; if (counter !== 32'd0) begin errors++; $display("FAIL idle_not_yet: got %0d expected 0", counter); end
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_back: got %b expected 1", cfg_ready); end
    checks++; if ({counter, on_counter} !== {32'd4, 32'd2}) begin errors++; $display("FAIL idle_commit: got %0d/%0d expected 4/2", counter, on_counter); end
    checks++; if ({k_rise, k_fall, amplitude} !== {16'd1, 16'd1, 16'd2}) begin errors++; $display("FAIL idle_commit_wave: got %0d/%0d/%0d expected 1/1/2", k_rise, k_fall, amplitude); end
    prescaler = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (cr !== 32'(i % 5)) begin errors++; $display("FAIL basic_cr[%0d]: got %0d expected %0d", i, cr, i % 5); end
      checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL basic_clk_en[%0d]: got %b expected 1", i, clk_en); end
      checks++; if (period_done !== (i != 0 && i % 5 == 0)) begin errors++; $display("FAIL basic_pdone[%0d]: got %b expected %b", i, period_done, (i != 0 && i % 5 == 0)); end
      step();
    end
  endtask

  task automatic test_stop();
    checks++; if (cr !== 32'd1) begin errors++; $display("FAIL stop_cr_start: got %0d expected 1", cr); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      checks++; if ({cr, busy, done} !== {32'(c), 1'b1, 1'b0}) begin errors++; $display("FAIL stop_drain[%0d]: got cr=%0d busy=%b done=%b expected cr=%0d busy=1 done=0", c, cr, busy, done, c); end
      step();
    end
    checks++; if ({busy, clk_en, cr} !== {1'b0, 1'b0, 32'd0}) begin errors++; $display("FAIL stop_idle: got busy=%b clk_en=%b cr=%0d expected 0 0 0", busy, clk_en, cr); end
    checks++; if ({done, period_done} !== 2'b11) begin errors++; $display("FAIL stop_pulses: got %b expected 11", {done, period_done}); end
    step();
    checks++; if ({done, period_done, busy} !== 3'b000) begin errors++; $display("FAIL stop_pulse_end: got %b expected 000", {done, period_done, busy}); end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if ({busy, clk_en} !== 2'b00) begin errors++; $display("FAIL start_stop_same: got %b expected 00", {busy, clk_en}); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_stay: got %b expected 0", busy); end
  endtask

  task automatic test_prescaler();
    load_idle(1, 0, 3, 3, 5);
    checks++; if (counter !== 32'd1) begin errors++; $display("FAIL presc_cfg: got %0d expected 1", counter); end
    prescaler = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      checks++; if (clk_en !== (j % 3 == 0)) begin errors++; $display("FAIL presc_clk_en[%0d]: got %b expected %b", j, clk_en, (j % 3 == 0)); end
      checks++; if (cr !== 32'(((j + 2) / 3) % 2)) begin errors++; $display("FAIL presc_cr[%0d]: got %0d expected %0d", j, cr, ((j + 2) / 3) % 2); end
      checks++; if (period_done !== (j % 6 == 4)) begin errors++; $display("FAIL presc_pdone[%0d]: got %b expected %b", j, period_done, (j % 6 == 4)); end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step(); step();
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL presc_stop: got busy=%b done=%b expected 0 1", busy, done); end
    step();
  endtask

  task automatic test_midcfg();
    load_idle(4, 2, 1, 1, 2);
    prescaler = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    set_cfg(7, 3, 9, 8, 100);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      checks++; if ({cfg_ready, cr, counter} !== {1'b0, 32'(i), 32'd4}) begin errors++; $display("FAIL mid_hold[%0d]: got ready=%b cr=%0d counter=%0d expected 0 %0d 4", i, cfg_ready, cr, counter, i); end
      step();
    end
    checks++; if ({cfg_ready, period_done, cr} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL mid_wrap: got ready=%b pdone=%b cr=%0d expected 1 1 0", cfg_ready, period_done, cr); end
    checks++; if ({counter, on_counter} !== {32'd7, 32'd3}) begin errors++; $display("FAIL mid_commit: got %0d/%0d expected 7/3", counter, on_counter); end
    checks++; if ({k_rise, k_fall, amplitude} !== {16'd9, 16'd8, 16'd100}) begin errors++; $display("FAIL mid_commit_wave: got %0d/%0d/%0d expected 9/8/100", k_rise, k_fall, amplitude); end
    for (int i = 5; i <= 13; i++) begin
      checks++; if (cr !== 32'((i - 5) % 8)) begin errors++; $display("FAIL mid_cr[%0d]: got %0d expected %0d", i, cr, (i - 5) % 8); end
      if (i != 13) step();
    end
    checks++; if (period_done !== 1'b1) begin errors++; $display("FAIL mid_pdone2: got %b expected 1", period_done); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int n = 0; n < 7; n++) step();
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL mid_stop: got busy=%b done=%b expected 0 1", busy, done); end
    step();
  endtask

`ifdef FG_BURST_EN
  task automatic test_burst();
    int ticks = 0, pdones = 0, dones = 0;
    load_idle(2, 1, 1, 1, 1);
    prescaler = 8'd0; burst_count = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      ticks += int'(clk_en); pdones += int'(period_done); dones += int'(done);
      step();
    end
    burst_count = '0;
    checks++; if (ticks !== 9) begin errors++; $display("FAIL burst_ticks: got %0d expected 9", ticks); end
    checks++; if (pdones !== 3) begin errors++; $display("FAIL burst_pdone: got %0d expected 3", pdones); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL burst_done: got %0d expected 1", dones); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy: got %b expected 0", busy); end
  endtask
`endif

  task automatic test_reset_midrun();
    prescaler = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    set_cfg(3, 1, 4, 4, 4);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++; if ({cfg_ready, busy} !== 2'b01) begin errors++; $display("FAIL rst_pending: got ready=%b busy=%b expected 0 1", cfg_ready, busy); end
    rstn = 1'b0;
    step();
    checks++; if ({busy, clk_en, cfg_ready, cr} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin errors++; $display("FAIL rst_state: got busy=%b clk_en=%b ready=%b cr=%0d expected 0 0 1 0", busy, clk_en, cfg_ready, cr); end
    checks++; if ({counter, on_counter, amplitude} !== '0) begin errors++; $display("FAIL rst_active: got %0d/%0d/%0d expected 0/0/0", counter, on_counter, amplitude); end
    rstn = 1'b1;
    step(); step();
    checks++; if ({cfg_ready, counter} !== {1'b1, 32'd0}) begin errors++; $display("FAIL rst_shadow_gone: got ready=%b counter=%0d expected 1 0", cfg_ready, counter); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop();
    test_prescaler();
    test_midcfg();
`ifdef FG_BURST_EN
    test_burst();
`endif
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fg_period_sequencer.md
# fg_period_sequencer

Sequencer and configuration front-end for the function-generator waveform datapath. Generates the datapath clock-enable from a prescaler and drives the period counter register (CR) that the waveform generator's state machine follows. Holds active and shadow copies of the waveform configuration, accepts updates over a valid/ready handshake, and commits them only at a period boundary so the generator never sees a torn parameter set. Sits between the register interface and the waveform generator.

## Interface
- COUNTER_BITWIDTH, 32, width of period/ON counters and CR
- WAVEFORM_BITWIDTH, 16, width of slopes and amplitude
- PRESCALER_BITWIDTH, 8, width of clock-enable divider
- BURST_BITWIDTH, 16, width of burst period count (FG_BURST_EN only)

- clk_i  in  1  system clock; one clock domain
- rstn_i  in  1  reset, synchronous, active-low
- start_i  in  1  start request (level sampled each cycle)
- stop_i  in  1  stop request; honoured at next period boundary
- prescaler_i  in  PRESCALER_BITWIDTH  divider value P; clk_en period = P+1 cycles
- burst_count_i  in  BURST_BITWIDTH  periods per burst, 0 = continuous (present only with FG_BURST_EN)
- cfg_valid_i  in  1  new configuration offered
- cfg_ready_o  out  1  shadow slot free
- cfg_period_i, cfg_on_i  in  COUNTER_BITWIDTH each  period end value, ON end value
- cfg_k_rise_i, cfg_k_fall_i, cfg_amplitude_i  in  WAVEFORM_BITWIDTH each  slopes, amplitude
- clk_en_o  out  1  datapath clock-enable
- CR_o  out  COUNTER_BITWIDTH  period counter register
- counter_o, ON_counter_o  out  COUNTER_BITWIDTH  active period / ON values
- k_rise_o, k_fall_o, amplitude_o  out  WAVEFORM_BITWIDTH  active slopes / amplitude
- busy_o  out  1  state != IDLE
- period_done_o  out  1  one-cycle pulse per completed period
- done_o  out  1  one-cycle pulse when run ends (stop or burst complete)

## Operation
- States: IDLE, RUN, STOPPING. Reset: IDLE, all outputs 0 except cfg_ready_o = 1; shadow empty; active config 0.
- IDLE: clk_en_o = 0, CR_o = 0. start_i=1 → RUN; latches prescaler_i (and burst_count_i); prescaler count cleared.
- Prescaler: count p runs 0..P, wraps to 0; clk_en_o = (state != IDLE) && p == 0. P = 0 → clk_en_o high every RUN cycle.
- CR: on each edge where clk_en_o = 1, CR_o ← (CR_o == counter_o) ? 0 : CR_o + 1. counter_o = 0 → CR_o stays 0, every tick is a wrap. Period length = counter_o+1 ticks.
- Wrap edge (clk_en_o = 1 and CR_o == counter_o): period_done_o pulses next cycle; pending shadow (if any) copied to active outputs, cfg_ready_o returns 1.
- Config handshake: transfer when cfg_valid_i && cfg_ready_o; all five fields captured into shadow, cfg_ready_o ← 0. In IDLE the shadow is committed to active on the following cycle (cfg_ready_o low exactly one cycle).
- stop_i in RUN → STOPPING. STOPPING keeps ticking; at the wrap edge → IDLE, CR_o = 0, done_o pulse. Pending commit at that same wrap still applies.
- start_i ignored unless IDLE. start_i and stop_i same cycle in IDLE: stop wins, remain IDLE. stop_i in IDLE: no effect.
- Reset mid-run: next edge returns to reset state; shadow contents discarded.

## Timing
- start_i sampled at edge t → busy_o and first clk_en_o high in cycle t+1; CR_o = 0 during that tick.
- CR_o and active config update on the same edge the datapath samples clk_en_o, so the datapath sees CR_o == 0 with the freshly committed config.
- Config accepted at edge t in RUN becomes active at the first wrap edge after t; never mid-period.
- period_done_o and done_o are registered, high one cycle after the wrap edge.
- No combinational path from any input to any output except none; clk_en_o decodes registers only.

## Configuration
- FG_BURST_EN defined: burst_count_i port exists; latched at start; non-zero N → after N wrap edges state → IDLE with done_o pulse, as if stop_i. N = 0 → continuous. stop_i still ends the run early at the next wrap.
- FG_BURST_EN undefined: no burst_count_i port, no burst counter; runs only end via stop_i.

## Test plan
- Reset, cfg {period=4, on=2, k_rise=1, k_fall=1, amp=2} in IDLE, P=0, start → clk_en_o every cycle, CR_o 0,1,2,3,4,0,...; period_done_o pulse every 5 cycles.
- P=2, period=1 → clk_en_o high 1 of every 3 cycles; CR_o toggles 0/1 only on enabled edges.
- Mid-period cfg write period=7 → cfg_ready_o low until wrap; CR_o completes old 0..4, next period counts 0..7; outputs change exactly at the wrap edge.
- stop_i at CR_o=1 → CR_o continues to 4, wraps, IDLE, done_o one pulse, clk_en_o 0; simultaneous start_i+stop_i in IDLE → stays IDLE.
- FG_BURST_EN, burst_count=3, period=2 → exactly 9 clk_en_o ticks, 3 period_done_o pulses, done_o once, busy_o low after.
- rstn_i low during RUN with shadow pending → next cycle IDLE, CR_o=0, active config 0, cfg_ready_o=1.
